// File: rtl/button_pkg.sv
// Shared constants for the pushbutton conditioner: channel indices and default timing.
package button_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_RESET = 2;
    localparam int NUM_BTN   = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_RATE     = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press pulse and optional
// auto-repeat (built only when BTN_AUTOREPEAT_EN is defined and REPEAT is set).
module btn_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
`ifdef BTN_AUTOREPEAT_EN
    input  logic hold,
`endif
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             accept;
    logic             rep_fire;

    // accept is the edge on which the debounced state takes the synchronised value
    assign accept = (s2_reg != state_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            s1_reg    <= raw;
            s2_reg    <= s1_reg;
            press_reg <= (accept & s2_reg) | rep_fire;
            if (s2_reg == state_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                state_reg <= s2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    generate
        if (REPEAT) begin : g_repeat
`ifdef BTN_AUTOREPEAT_EN
            logic [CNT_W-1:0] rcnt_reg;

            // After the first repeat the counter reloads so the next one lands REPEAT_RATE later
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rcnt_reg <= '0;
                end else if (accept || !state_reg) begin
                    rcnt_reg <= '0;
                end else if (!hold) begin
                    if (rcnt_reg == CNT_W'(REPEAT_DELAY - 1))
                        rcnt_reg <= CNT_W'(REPEAT_DELAY - REPEAT_RATE);
                    else
                        rcnt_reg <= rcnt_reg + CNT_W'(1);
                end
            end

            assign rep_fire = state_reg && !accept && !hold &&
                              (rcnt_reg == CNT_W'(REPEAT_DELAY - 1));
`else
            assign rep_fire = 1'b0;
`endif
        end else begin : g_no_repeat
`ifdef BTN_AUTOREPEAT_EN
            logic unused_hold;
            assign unused_hold = hold;
`endif
            assign rep_fire = 1'b0;
        end
    endgenerate

    assign level = state_reg;
    assign press = press_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the left/right/reset pushbuttons into debounced levels and press pulses.
// Auto-repeat for left/right is compiled in with BTN_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               leftbutton,
    output logic               rightbutton,
    output logic               resetbutton,
    output logic               left_press,
    output logic               right_press,
    output logic               reset_press
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

`ifdef BTN_AUTOREPEAT_EN
    // Holding left and right together freezes both repeat counters
    logic both_held;
    assign both_held = level[BTN_LEFT] & level[BTN_RIGHT];
`endif

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .REPEAT          (gi != BTN_RESET)
            ) u_ch (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_raw[gi]),
`ifdef BTN_AUTOREPEAT_EN
                .hold  (both_held),
`endif
                .level (level[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    assign leftbutton  = level[BTN_LEFT];
    assign rightbutton = level[BTN_RIGHT];
    assign resetbutton = level[BTN_RESET];
    assign left_press  = press[BTN_LEFT];
    assign right_press = press[BTN_RIGHT];
    assign reset_press = press[BTN_RESET];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4.
// Expectations follow BTN_AUTOREPEAT_EN so the same bench covers both builds.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic       leftbutton, rightbutton, resetbutton;
    logic       left_press, right_press, reset_press;
    logic [5:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .leftbutton  (leftbutton),
        .rightbutton (rightbutton),
        .resetbutton (resetbutton),
        .left_press  (left_press),
        .right_press (right_press),
        .reset_press (reset_press)
    );

    assign outs = {reset_press, right_press, left_press, resetbutton, rightbutton, leftbutton};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_raw = 3'b000;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        btn_raw = 3'b111;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: outputs %b, required 000000", e, outs);
            end
        end
        btn_raw = 3'b000;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: outputs %b, required 000000", e, outs);
            end
        end
        $display("test_reset complete");
    endtask

    task automatic test_clean_press();
        logic exp_lvl, exp_p;
        btn_raw = 3'b001;
        for (int e = 0; e <= 16; e++) begin
            tick();
            if (e == 5) btn_raw = 3'b000;
            exp_lvl = (e >= 5) && (e < 11);
            exp_p   = (e == 5);
            n_checks++;
            if (leftbutton !== exp_lvl) begin
                n_fail++;
                $display("FAIL clean_level edge %0d: leftbutton %b, required %b", e, leftbutton, exp_lvl);
            end
            n_checks++;
            if (left_press !== exp_p) begin
                n_fail++;
                $display("FAIL clean_pulse edge %0d: left_press %b, required %b", e, left_press, exp_p);
            end
        end
        settle();
        $display("test_clean_press complete");
    endtask

    task automatic test_bounce();
        for (int e = 0; e < 32; e++) begin
            btn_raw = {1'b0, ((e % 4) != 3), 1'b0};
            tick();
            n_checks++;
            if ({rightbutton, right_press} !== 2'b00) begin
                n_fail++;
                $display("FAIL bounce edge %0d: rightbutton %b right_press %b, required 0 0",
                         e, rightbutton, right_press);
            end
        end
        settle();
        $display("test_bounce complete");
    endtask

    task automatic test_autorepeat();
        logic exp_lvl, exp_p;
        btn_raw = 3'b001;
        for (int e = 0; e <= 30; e++) begin
            tick();
            exp_lvl = (e >= 5);
            exp_p   = (e == 5) || (AR && (e >= 13) && (((e - 13) % 4) == 0));
            n_checks++;
            if (leftbutton !== exp_lvl) begin
                n_fail++;
                $display("FAIL repeat_level edge %0d: leftbutton %b, required %b", e, leftbutton, exp_lvl);
            end
            n_checks++;
            if (left_press !== exp_p) begin
                n_fail++;
                $display("FAIL repeat_pulse edge %0d: left_press %b, required %b", e, left_press, exp_p);
            end
        end
        btn_raw = 3'b000;
        for (int e = 31; e <= 40; e++) begin
            tick();
            exp_lvl = (e < 36);
            n_checks++;
            if (leftbutton !== exp_lvl) begin
                n_fail++;
                $display("FAIL repeat_release edge %0d: leftbutton %b, required %b", e, leftbutton, exp_lvl);
            end
        end
        settle();
        $display("test_autorepeat complete");
    endtask

    task automatic test_simultaneous();
        logic exp_lvl, exp_p, exp_r_lvl;
        btn_raw = 3'b011;
        for (int e = 0; e <= 20; e++) begin
            tick();
            exp_lvl = (e >= 5);
            exp_p   = (e == 5);
            n_checks++;
            if ({leftbutton, rightbutton} !== {exp_lvl, exp_lvl}) begin
                n_fail++;
                $display("FAIL simul_level edge %0d: left %b right %b, required %b %b",
                         e, leftbutton, rightbutton, exp_lvl, exp_lvl);
            end
            n_checks++;
            if ({left_press, right_press} !== {exp_p, exp_p}) begin
                n_fail++;
                $display("FAIL simul_pulse edge %0d: left_press %b right_press %b, required %b %b",
                         e, left_press, right_press, exp_p, exp_p);
            end
        end
        btn_raw = 3'b001;
        for (int e = 21; e <= 44; e++) begin
            tick();
            exp_r_lvl = (e < 26);
            exp_p     = AR && ((e == 34) || (e == 38) || (e == 42));
            n_checks++;
            if ({leftbutton, rightbutton} !== {1'b1, exp_r_lvl}) begin
                n_fail++;
                $display("FAIL resume_level edge %0d: left %b right %b, required 1 %b",
                         e, leftbutton, rightbutton, exp_r_lvl);
            end
            n_checks++;
            if ({left_press, right_press} !== {exp_p, 1'b0}) begin
                n_fail++;
                $display("FAIL resume_pulse edge %0d: left_press %b right_press %b, required %b 0",
                         e, left_press, right_press, exp_p);
            end
        end
        settle();
        $display("test_simultaneous complete");
    endtask

    task automatic test_reset_mid();
        logic exp_lvl, exp_p;
        btn_raw = 3'b001;
        for (int e = 0; e <= 2; e++) begin
            tick();
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL mid_pre edge %0d: outputs %b, required 000000", e, outs);
            end
        end
        reset = 1'b1;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) tick();
            else #1;
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL mid_in_reset step %0d: outputs %b, required 000000", e, outs);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_lvl = (k >= 6);
            exp_p   = (k == 6);
            n_checks++;
            if (leftbutton !== exp_lvl) begin
                n_fail++;
                $display("FAIL mid_level edge %0d after release: leftbutton %b, required %b", k, leftbutton, exp_lvl);
            end
            n_checks++;
            if (left_press !== exp_p) begin
                n_fail++;
                $display("FAIL mid_pulse edge %0d after release: left_press %b, required %b", k, left_press, exp_p);
            end
        end
        settle();
        $display("test_reset_mid complete");
    endtask

    task automatic test_reset_channel();
        logic exp_lvl, exp_p;
        btn_raw = 3'b100;
        for (int e = 0; e <= 29; e++) begin
            tick();
            exp_lvl = (e >= 5);
            exp_p   = (e == 5);
            n_checks++;
            if ({resetbutton, reset_press} !== {exp_lvl, exp_p}) begin
                n_fail++;
                $display("FAIL rstreq edge %0d: resetbutton %b reset_press %b, required %b %b",
                         e, resetbutton, reset_press, exp_lvl, exp_p);
            end
            n_checks++;
            if ({outs[4:3], outs[1:0]} !== 4'b0) begin
                n_fail++;
                $display("FAIL rstreq_isolation edge %0d: outputs %b, required left/right all 0", e, outs);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %b, required 000000", outs);
        end
        btn_raw = 3'b000;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL post_reset edge %0d: outputs %b, required 000000", k, outs);
            end
        end
        $display("test_reset_channel complete");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid();
        test_reset_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the three raw pushbuttons (left, right, reset) for the pong display stage. Each button is synchronised, debounced, and converted into a clean level plus a single-cycle press pulse. With auto-repeat enabled, a held left or right button also emits repeated press pulses. The outputs drive the display stage's `leftbutton`, `rightbutton` and `resetbutton` inputs directly, all in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples needed to accept a change; must be ≥ 2.
- `REPEAT_DELAY`, default 64: held cycles from the press pulse to the first repeat pulse.
- `REPEAT_RATE`, default 16: cycles between later repeat pulses.
- Counter widths are derived with `$clog2` of the largest parameter.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `btn_raw`, in, 3: raw, unsynchronised buttons, active-high; bit 0 = left, bit 1 = right, bit 2 = reset request.
- `leftbutton`, out, 1: debounced left level.
- `rightbutton`, out, 1: debounced right level.
- `resetbutton`, out, 1: debounced reset-request level.
- `left_press`, out, 1: one-cycle press pulse for left, including repeat pulses.
- `right_press`, out, 1: one-cycle press pulse for right, including repeat pulses.
- `reset_press`, out, 1: one-cycle press pulse for reset; never repeats.

## Operation
- **Reset values.** While `reset` is high, every output is 0. Synchroniser flops, debounce counters, repeat counters and debounced states are also cleared. Reset takes effect immediately and is safe mid-debounce or mid-repeat; no pulse is emitted on reset release.
- **Channels.** Each of the 3 channels is independent and identical apart from repeat eligibility.
- **Synchroniser.** Two flops: `s1 <= raw`, `s2 <= s1`.
- **Debounce, on each `clk` edge:**
  - If `s2 == state`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `state <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any bounce back to `state` before acceptance restarts the count.
- **Press pulse.** A registered pulse asserted on the same edge that `state` goes 0→1. Release (1→0) emits nothing.
- **Auto-repeat** (left/right only, when compiled in):
  - `rcnt` clears on the press edge and increments each cycle while `state` = 1.
  - A pulse fires when `rcnt` reaches `REPEAT_DELAY`. After that, `rcnt` reloads so pulses follow every `REPEAT_RATE` cycles.
  - `rcnt` clears on release.
  - While both left and right debounced levels are 1, repeat pulses are suppressed and both repeat counters hold. Initial press pulses are still emitted.
- **Simultaneous events.** Left and right presses accepted on the same edge give both pulses in the same cycle. A reset-request press does not affect the other channels.

## Timing
- **Press latency.** If `btn_raw` bit goes high before edge 0 and stays high, `s2` is 1 after edge 1 and the level plus pulse assert after edge `DEBOUNCE_CYCLES+1`. The release level drops with the same latency.
- **Pulse width.** Press pulses are exactly 1 cycle. Consecutive repeat pulses are never adjacent, because `REPEAT_RATE` ≥ 2 is required.
- **Repeat schedule.** First repeat at press edge + `REPEAT_DELAY`, then every `REPEAT_RATE` edges.
- **Glitch rejection.** A pulse on `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no output change.

## Configuration
- The `BTN_AUTOREPEAT_EN` macro controls auto-repeat.
  - **Defined:** the repeat counters and suppression logic are built, and left/right behave as above.
  - **Undefined:** the repeat logic is absent; each accepted press gives exactly one pulse, and `REPEAT_DELAY` and `REPEAT_RATE` are ignored.
- `reset_press` never repeats in either build.

## Structure
- **Shared package `button_pkg`:**
  - Index constants `BTN_LEFT`=0, `BTN_RIGHT`=1, `BTN_RESET`=2, and `NUM_BTN`=3.
  - Default parameter constants.
- **Sub-module `btn_debounce_ch`:** one channel containing the synchroniser, debounce counter, state, press pulse, and optional repeat (enabled by a per-instance `REPEAT` parameter). It is instantiated 3 times.
- **Top level:** channel instances plus the left/right repeat-suppression cross-coupling.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_RATE`=4.

1. **Clean press.** Left goes high before edge 0 and is held 6 cycles → `leftbutton` = 1 and `left_press` = 1 for one cycle after edge 5. The release gives the level low 5 edges after the raw fall, with no pulse.
2. **Bounce rejection.** Right raw pattern 1,1,1,0,1,1,1,0 repeating → `rightbutton` stays 0 and no `right_press` is emitted.
3. **Auto-repeat.** Left held 30 cycles → `left_press` after edges 5, 13, 17, 21, 25, 29. Built without `BTN_AUTOREPEAT_EN` → a pulse after edge 5 only.
4. **Simultaneous press.** Left and right rise on the same cycle and are held → both pulses after edge 5, then no repeats while both are held. Releasing right → left repeats resume from its held counter value.
5. **Reset mid-operation.** `reset` is asserted at edge 3 of a left press (debounce count 1) and released 2 cycles later while raw is still high → all outputs are 0 during reset. The press is re-debounced and gives exactly one pulse 6 edges after reset release (2 synchroniser edges + 4 debounce edges).
6. **Reset-request channel.** Bit 2 held 30 cycles → `resetbutton` = 1 after edge 5 and exactly one `reset_press` in both builds.
